// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// Instruction-fetch stage front end. Keeps the fetch PC, strobes a one-cycle-latency instruction
// memory, and presents each returned instruction with its PC+4 to the IF_ID register. While the
// downstream stage stalls, the presented instruction is parked in hold registers. A redirect
// (branch/jump taken) squashes the in-flight fetch and restarts fetching at the target.
//
// Parameters
//   n        datapath / PC width in bits
//   RESET_PC first fetch address after reset
//
// Ports
//   clk                   rising-edge clock
//   reset_in              asynchronous active-low reset
//   stall_in              hazard stall (IF_ID enable is its inverse)
//   redirect_in           one-cycle taken-branch/jump pulse, has priority over stall_in
//   redirect_pc_in        redirect target (low two bits ignored)
//   imem_req_out          instruction memory read strobe
//   imem_addr_out         instruction memory address (always the fetch PC)
//   imem_rdata_in         read data, valid one cycle after a strobed request
//   PC_Counter_output_out PC+4 of the presented instruction (0 when not valid)
//   Instruction_memory_out presented instruction (0 when not valid)
//   if_valid_out          presented instruction is on the correct path
//   fetch_cnt_out         (only with IF_PERF_CNT_EN) saturating count of accepted instructions
//
// Build option: define IF_PERF_CNT_EN to add the fetch_cnt_out performance counter.
module if_fetch_unit #(
    parameter int unsigned    n        = 32,
    parameter logic [n-1:0]   RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset_in,
    input  logic         stall_in,
    input  logic         redirect_in,
    input  logic [n-1:0] redirect_pc_in,
    output logic         imem_req_out,
    output logic [n-1:0] imem_addr_out,
    input  logic [n-1:0] imem_rdata_in,
    output logic [n-1:0] PC_Counter_output_out,
    output logic [n-1:0] Instruction_memory_out,
    output logic         if_valid_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]  fetch_cnt_out
`endif
);

    localparam logic [n-1:0] PcStep = n'(4);

    typedef enum logic [0:0] {StRun, StHold} state_e;

    state_e       state_q, state_d;
    logic [n-1:0] pc_q, pc_d;
    logic         pend_q, pend_d;
    logic [n-1:0] pend_pc_q, pend_pc_d;
    logic [n-1:0] hold_instr_q, hold_instr_d;
    logic [n-1:0] hold_pc_q, hold_pc_d;

    assign imem_addr_out = pc_q;

    // A request goes out whenever the next stage can accept and nothing is being squashed.
    // This covers HOLD too: the cycle stall_in falls, the held instruction is consumed and the
    // next fetch is issued together, so no bubble appears. reset_in gates it so the strobe is
    // low for the whole reset interval.
    assign imem_req_out = reset_in & ~stall_in & ~redirect_in;

    always_comb begin
        state_d                = state_q;
        pc_d                   = pc_q;
        pend_d                 = 1'b0;
        pend_pc_d              = pend_pc_q;
        hold_instr_d           = hold_instr_q;
        hold_pc_d              = hold_pc_q;
        if_valid_out           = 1'b0;
        Instruction_memory_out = '0;
        PC_Counter_output_out  = '0;

        unique case (state_q)
            StRun: begin
                if (pend_q) begin
                    if_valid_out           = 1'b1;
                    Instruction_memory_out = imem_rdata_in;
                    PC_Counter_output_out  = pend_pc_q + PcStep;
                end
            end
            StHold: begin
                if_valid_out           = 1'b1;
                Instruction_memory_out = hold_instr_q;
                PC_Counter_output_out  = hold_pc_q;
            end
            default: ;
        endcase

        if (redirect_in) begin
            // Squash whatever is presented (including a held instruction) and restart.
            if_valid_out           = 1'b0;
            Instruction_memory_out = '0;
            PC_Counter_output_out  = '0;
            pc_d                   = {redirect_pc_in[n-1:2], 2'b00};
            state_d                = StRun;
        end else if (imem_req_out) begin
            pc_d      = pc_q + PcStep;
            pend_pc_d = pc_q;
            pend_d    = 1'b1;
            state_d   = StRun;
        end else if (state_q == StRun && pend_q && stall_in) begin
            // Memory data is only valid for one cycle, so park it before it disappears.
            hold_instr_d = imem_rdata_in;
            hold_pc_d    = pend_pc_q + PcStep;
            state_d      = StHold;
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q      <= StRun;
            pc_q         <= RESET_PC;
            pend_q       <= 1'b0;
            pend_pc_q    <= '0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    // Counts instructions actually accepted by IF_ID; sticks at all-ones.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (if_valid_out && !stall_in && !redirect_in && fetch_cnt_q != 32'hFFFF_FFFF) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            fetch_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign fetch_cnt_out = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic [31:0] imem_rdata_in;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        if_valid_out;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_out;
`endif

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    logic [31:0] mem_key = 32'h0;

    if_fetch_unit #(
        .n        (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk                    (clk),
        .reset_in               (reset_in),
        .stall_in               (stall_in),
        .redirect_in            (redirect_in),
        .redirect_pc_in         (redirect_pc_in),
        .imem_req_out           (imem_req_out),
        .imem_addr_out          (imem_addr_out),
        .imem_rdata_in          (imem_rdata_in),
        .PC_Counter_output_out  (pc_out),
        .Instruction_memory_out (instr_out),
        .if_valid_out           (if_valid_out)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_out          (fetch_cnt_out)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: one-cycle read latency, content = address XOR key.
    always @(posedge clk) begin
        if (imem_req_out) imem_rdata_in <= imem_addr_out ^ mem_key;
    end

    // {req, addr, valid, instr, pc}
    function automatic logic [97:0] snap();
        return {imem_req_out, imem_addr_out, if_valid_out, instr_out, pc_out};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [97:0] exp;
        reset_in = 1'b0; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc_in = '0;
        next_cycle();
        next_cycle();
        exp = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        n_total++;
        if (snap() !== exp) $display("FAIL reset_hold: got %h want %h", snap(), exp);
        else n_pass++;
        reset_in = 1'b1;
        #1;
        exp = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
        n_total++;
        if (snap() !== exp) $display("FAIL reset_first_req: got %h want %h", snap(), exp);
        else n_pass++;
    endtask

    task automatic test_sequential();
        logic [97:0] exp;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            exp = {1'b1, 32'(4 * i + 4), 1'b1, 32'(4 * i), 32'(4 * i + 4)};
            n_total++;
            if (snap() !== exp) $display("FAIL seq_%0d: got %h want %h", i, snap(), exp);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        logic [97:0] exp;
        next_cycle();
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) next_cycle();
            #1;
            exp = {1'b0, 32'hC, 1'b1, 32'h8, 32'hC};
            n_total++;
            if (snap() !== exp) $display("FAIL stall_hold_%0d: got %h want %h", i, snap(), exp);
            else n_pass++;
        end
        next_cycle();
        stall_in = 1'b0;
        #1;
        exp = {1'b1, 32'hC, 1'b1, 32'h8, 32'hC};
        n_total++;
        if (snap() !== exp) $display("FAIL stall_release: got %h want %h", snap(), exp);
        else n_pass++;
        next_cycle();
        exp = {1'b1, 32'h10, 1'b1, 32'hC, 32'h10};
        n_total++;
        if (snap() !== exp) $display("FAIL stall_next: got %h want %h", snap(), exp);
        else n_pass++;
    endtask

    task automatic test_redirect();
        logic [97:0] exp;
        redirect_in = 1'b1; redirect_pc_in = 32'h0000_0103;
        #1;
        exp = {1'b0, 32'h10, 1'b0, 32'h0, 32'h0};
        n_total++;
        if (snap() !== exp) $display("FAIL redir_cycle: got %h want %h", snap(), exp);
        else n_pass++;
        next_cycle();
        redirect_in = 1'b0;
        #1;
        exp = {1'b1, 32'h100, 1'b0, 32'h0, 32'h0};
        n_total++;
        if (snap() !== exp) $display("FAIL redir_bubble: got %h want %h", snap(), exp);
        else n_pass++;
        next_cycle();
        exp = {1'b1, 32'h104, 1'b1, 32'h100, 32'h104};
        n_total++;
        if (snap() !== exp) $display("FAIL redir_target: got %h want %h", snap(), exp);
        else n_pass++;
    endtask

    task automatic test_redirect_hold();
        logic [97:0] exp;
        stall_in = 1'b1;
        #1;
        exp = {1'b0, 32'h104, 1'b1, 32'h100, 32'h104};
        n_total++;
        if (snap() !== exp) $display("FAIL rh_enter: got %h want %h", snap(), exp);
        else n_pass++;
        next_cycle();
        redirect_in = 1'b1; redirect_pc_in = 32'h0000_0100;
        #1;
        exp = {1'b0, 32'h104, 1'b0, 32'h0, 32'h0};
        n_total++;
        if (snap() !== exp) $display("FAIL rh_squash: got %h want %h", snap(), exp);
        else n_pass++;
        next_cycle();
        redirect_in = 1'b0;
        #1;
        exp = {1'b0, 32'h100, 1'b0, 32'h0, 32'h0};
        n_total++;
        if (snap() !== exp) $display("FAIL rh_stalled: got %h want %h", snap(), exp);
        else n_pass++;
        next_cycle();
        stall_in = 1'b0;
        #1;
        exp = {1'b1, 32'h100, 1'b0, 32'h0, 32'h0};
        n_total++;
        if (snap() !== exp) $display("FAIL rh_fetch: got %h want %h", snap(), exp);
        else n_pass++;
        next_cycle();
        exp = {1'b1, 32'h104, 1'b1, 32'h100, 32'h104};
        n_total++;
        if (snap() !== exp) $display("FAIL rh_target: got %h want %h", snap(), exp);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [97:0] exp;
        redirect_in = 1'b1; redirect_pc_in = 32'hFFFF_FFFC;
        next_cycle();
        redirect_in = 1'b0;
        #1;
        exp = {1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0};
        n_total++;
        if (snap() !== exp) $display("FAIL wrap_fetch: got %h want %h", snap(), exp);
        else n_pass++;
        next_cycle();
        exp = {1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h0};
        n_total++;
        if (snap() !== exp) $display("FAIL wrap_present: got %h want %h", snap(), exp);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        logic [97:0] exp;
        next_cycle();
        stall_in = 1'b1;
        next_cycle();
        #1;
        exp = {1'b0, 32'h4, 1'b1, 32'h0, 32'h4};
        n_total++;
        if (snap() !== exp) $display("FAIL rms_held: got %h want %h", snap(), exp);
        else n_pass++;
        #2;
        reset_in = 1'b0;
        #1;
        exp = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
        n_total++;
        if (snap() !== exp) $display("FAIL rms_async: got %h want %h", snap(), exp);
        else n_pass++;
`ifdef IF_PERF_CNT_EN
        n_total++;
        if (fetch_cnt_out !== 32'd0) $display("FAIL rms_cnt_zero: got %0d want 0", fetch_cnt_out);
        else n_pass++;
`endif
        next_cycle();
        reset_in = 1'b1; stall_in = 1'b0;
        #1;
        exp = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
        n_total++;
        if (snap() !== exp) $display("FAIL rms_restart: got %h want %h", snap(), exp);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            exp = {1'b1, 32'(4 * i + 4), 1'b1, 32'(4 * i), 32'(4 * i + 4)};
            n_total++;
            if (snap() !== exp) $display("FAIL rms_seq_%0d: got %h want %h", i, snap(), exp);
            else n_pass++;
        end
        next_cycle();
`ifdef IF_PERF_CNT_EN
        n_total++;
        if (fetch_cnt_out !== 32'd5) $display("FAIL rms_cnt_five: got %0d want 5", fetch_cnt_out);
        else n_pass++;
`endif
    endtask

    // Reference rules: an instruction becomes valid the cycle after a request and stays
    // presented while stalled unless squashed; accepted instructions form a sequential stream
    // from the last redirect target; fetches form a sequential address stream likewise.
    task automatic test_random();
        logic [31:0] exp_pc, exp_fetch, cnt;
        logic        prev_req, prev_valid, prev_stall, prev_redir, exp_valid, exp_req;
        int unsigned errs_before;
        mem_key = $urandom;
        reset_in = 1'b0; stall_in = 1'b0; redirect_in = 1'b0;
        next_cycle();
        reset_in = 1'b1;
        exp_pc = 32'h0; exp_fetch = 32'h0; cnt = 32'h0;
        prev_req = 1'b0; prev_valid = 1'b0; prev_stall = 1'b0; prev_redir = 1'b0;
        errs_before = n_total - n_pass;
        for (int i = 0; i < 1500; i++) begin
            stall_in       = ($urandom_range(0, 9) < 3);
            redirect_in    = ($urandom_range(0, 9) == 0);
            redirect_pc_in = $urandom;
            #1;
            exp_req   = !stall_in && !redirect_in;
            exp_valid = !redirect_in && (prev_req || (prev_valid && prev_stall && !prev_redir));
            n_total++;
            if (if_valid_out !== exp_valid || imem_req_out !== exp_req)
                $display("FAIL rnd_ctrl_%0d: valid=%b req=%b want valid=%b req=%b",
                         i, if_valid_out, imem_req_out, exp_valid, exp_req);
            else n_pass++;
            if (exp_req) begin
                n_total++;
                if (imem_addr_out !== exp_fetch)
                    $display("FAIL rnd_addr_%0d: got %h want %h", i, imem_addr_out, exp_fetch);
                else n_pass++;
                exp_fetch = exp_fetch + 32'd4;
            end
            if (!exp_valid) begin
                n_total++;
                if (instr_out !== 32'h0 || pc_out !== 32'h0)
                    $display("FAIL rnd_nop_%0d: instr=%h pc=%h want 0 0", i, instr_out, pc_out);
                else n_pass++;
            end else if (!stall_in) begin
                n_total++;
                if (instr_out !== (exp_pc ^ mem_key) || pc_out !== exp_pc + 32'd4)
                    $display("FAIL rnd_accept_%0d: instr=%h pc=%h want %h %h",
                             i, instr_out, pc_out, exp_pc ^ mem_key, exp_pc + 32'd4);
                else n_pass++;
                exp_pc = exp_pc + 32'd4;
            end
`ifdef IF_PERF_CNT_EN
            n_total++;
            if (fetch_cnt_out !== cnt)
                $display("FAIL rnd_cnt_%0d: got %0d want %0d", i, fetch_cnt_out, cnt);
            else n_pass++;
            if (exp_valid && !stall_in) cnt = cnt + 32'd1;
`endif
            if (redirect_in) begin
                exp_pc    = {redirect_pc_in[31:2], 2'b00};
                exp_fetch = {redirect_pc_in[31:2], 2'b00};
            end
            prev_req   = exp_req;
            prev_valid = exp_valid;
            prev_stall = stall_in;
            prev_redir = redirect_in;
            next_cycle();
            if (n_total - n_pass > errs_before + 20) break;
        end
    endtask

    initial begin
        reset_in = 1'b0; stall_in = 1'b0; redirect_in = 1'b0; redirect_pc_in = '0;
        #2;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_redirect_hold();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
